// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operating-mode
// encoding and its type.
package univ_shift_reg_pkg;

    // Two-bit operation select carried on the mode port.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: a D flip-flop with an
// asynchronous reset to a per-bit value, synchronous set/clear, a clock
// enable, and a 4:1 next-state mux (hold / right neighbour / left neighbour /
// parallel data).
module usr_bit_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0,
    parameter logic SET_BIT   = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  set,
    input  logic  clr,
    input  mode_t mode,
    input  logic  right_in,
    input  logic  left_in,
    input  logic  d_in,
    output logic  q
);

    logic nxt;

    // Next-state select; every mode code is decoded so an unused serial
    // input can never reach q.
    always_comb begin
        nxt = q;
        case (mode)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = right_in;
            MODE_SHL:  nxt = left_in;
            MODE_LOAD: nxt = d_in;
            default:   nxt = q;
        endcase
    end

    // Storage bit: async reset, then set over clear over enabled mode update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_BIT;
        end else if (set) begin
            q <= SET_BIT;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift right, shift left and
// parallel load, with asynchronous reset and synchronous set/clear.
// Optional shift counter enabled by defining UNIV_SHIFT_REG_CNT_EN, which adds
// the shift_cnt and shift_done outputs.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       set,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_r,
    input  logic                       sin_l,
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l
`ifdef UNIV_SHIFT_REG_CNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       shift_done
`endif
);

    // Neighbour chains: bit i shifts right from chain_r[i+1] (sin_r above
    // the MSB) and shifts left from chain_l[i] (sin_l below the LSB).
    logic [WIDTH:0] chain_r;
    logic [WIDTH:0] chain_l;

    assign chain_r = {sin_r, q};
    assign chain_l = {q, sin_l};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            usr_bit_cell #(
                .RESET_BIT (RESET_VAL[i]),
                .SET_BIT   (SET_VAL[i])
            ) u_cell (
                .clk      (clk),
                .reset    (reset),
                .en       (en),
                .set      (set),
                .clr      (clr),
                .mode     (mode_t'(mode)),
                .right_in (chain_r[i+1]),
                .left_in  (chain_l[i]),
                .d_in     (d[i]),
                .q        (q[i])
            );
        end
    endgenerate

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

`ifdef UNIV_SHIFT_REG_CNT_EN
    localparam int                 CNT_W   = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_PRE = CNT_W'(WIDTH - 1);

    logic shift_op;

    assign shift_op = en && !set && !clr &&
                      ((mode_t'(mode) == MODE_SHR) || (mode_t'(mode) == MODE_SHL));

    // Saturating shift counter with a one-cycle pulse on reaching WIDTH;
    // any set, clear or load restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_cnt  <= '0;
            shift_done <= 1'b0;
        end else begin
            shift_done <= 1'b0;
            if (set || clr) begin
                shift_cnt <= '0;
            end else if (en && (mode_t'(mode) == MODE_LOAD)) begin
                shift_cnt <= '0;
            end else if (shift_op && (shift_cnt != CNT_MAX)) begin
                shift_cnt  <= shift_cnt + 1'b1;
                shift_done <= (shift_cnt == CNT_PRE);
            end
        end
    end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8). Directed scenarios plus a
// randomized run against a behavioural model; counter checks compile in when
// UNIV_SHIFT_REG_CNT_EN is defined.
`timescale 1ns/1ps
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic       set;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
`ifdef UNIV_SHIFT_REG_CNT_EN
    logic [3:0] shift_cnt;
    logic       shift_done;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .set        (set),
        .clr        (clr),
        .mode       (mode),
        .d          (d),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l)
`ifdef UNIV_SHIFT_REG_CNT_EN
        ,
        .shift_cnt  (shift_cnt),
        .shift_done (shift_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural next value: arithmetic on the register as a number.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic s,
                                            input logic c, input logic e,
                                            input logic [1:0] m, input logic [7:0] dd,
                                            input logic sr, input logic sl);
        int v;
        if (s) return 8'hFF;
        if (c) return 8'h00;
        if (!e) return cur;
        v = int'(cur);
        case (m)
            2'd1:    v = (v / 2) + (sr ? 128 : 0);
            2'd2:    v = ((v * 2) % 256) + (sl ? 1 : 0);
            2'd3:    v = int'(dd);
            default: v = int'(cur);
        endcase
        return 8'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (q !== 8'h00 || sout_r !== 1'b0 || sout_l !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h sout_r=%b sout_l=%b, want q=00 sout 0/0", q, sout_r, sout_l);
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hA5;
        tick();
        n_tests++;
        if (q !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_preload: q=%h want a5", q);
        end
        @(negedge clk);
        #3;
        reset = 1'b1;
        #0.5;
        n_tests++;
        if (q !== 8'h00 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h sout_l=%b sout_r=%b want q=00 sout 0/0", q, sout_l, sout_r);
        end
        d = 8'hFF;
        tick();
        n_tests++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held: q=%h want 00", q);
        end
        reset = 1'b0; mode = 2'b00;
        tick();
        n_tests++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release_hold: q=%h want 00", q);
        end
        model = 8'h00;
    endtask

    task automatic test_load_shift_right();
        en = 1'b1; mode = 2'b11; d = 8'hB4;
        tick();
        n_tests++;
        if (q !== 8'hB4) begin
            n_fail++;
            $display("FAIL load_b4: q=%h want b4", q);
        end
        mode = 2'b01; sin_r = 1'b1;
        tick();
        n_tests++;
        if (q !== 8'hDA || sout_r !== 1'b0 || sout_l !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_1: q=%h sout_r=%b sout_l=%b want da 0 1", q, sout_r, sout_l);
        end
        tick();
        n_tests++;
        if (q !== 8'hED || sout_r !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_2: q=%h sout_r=%b want ed 1", q, sout_r);
        end
        model = 8'hED;
    endtask

    task automatic test_shift_left_en();
        en = 1'b1; mode = 2'b11; d = 8'h81;
        tick();
        mode = 2'b10; sin_l = 1'b0;
        tick();
        n_tests++;
        if (q !== 8'h02 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_81: q=%h want 02", q);
        end
        en = 1'b0; sin_l = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (q !== 8'h02) begin
                n_fail++;
                $display("FAIL en_gate_%0d: q=%h want 02", k, q);
            end
        end
        model = 8'h02;
    endtask

    task automatic test_set_clr();
        set = 1'b1; clr = 1'b1; en = 1'b0; mode = 2'b00;
        tick();
        n_tests++;
        if (q !== 8'hFF) begin
            n_fail++;
            $display("FAIL set_over_clr: q=%h want ff", q);
        end
        set = 1'b0; clr = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h3C;
        tick();
        n_tests++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_over_load: q=%h want 00", q);
        end
        set = 1'b1; clr = 1'b0; mode = 2'b11; d = 8'h12;
        tick();
        n_tests++;
        if (q !== 8'hFF) begin
            n_fail++;
            $display("FAIL set_over_load: q=%h want ff", q);
        end
        set = 1'b0; en = 1'b0; clr = 1'b1;
        tick();
        n_tests++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_no_en: q=%h want 00", q);
        end
        clr = 1'b0;
        model = 8'h00;
    endtask

    task automatic test_glitch();
        logic [7:0] fin;
        logic [7:0] exp;
        fin = 8'($urandom);
        @(negedge clk);
        en = 1'b1; mode = 2'b11; d = ~fin;
        #2 d = 8'($urandom);
        #1 d = fin ^ 8'h5A;
        #1 d = fin;
        tick();
        n_tests++;
        if (q !== fin) begin
            n_fail++;
            $display("FAIL glitch_load: q=%h want %h", q, fin);
        end
        exp = {1'b0, fin[7:1]};
        @(negedge clk);
        mode = 2'b01; sin_r = 1'b1;
        #2 sin_r = 1'b0;
        #1 sin_r = 1'b1;
        #1 sin_r = 1'b0;
        tick();
        n_tests++;
        if (q !== exp) begin
            n_fail++;
            $display("FAIL glitch_shr: q=%h want %h", q, exp);
        end
        model = exp;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        logic       s, c;
        int         cnt_m;
        logic       done_m;
        en = 1'b1; mode = 2'b11; d = 8'h00; set = 1'b0; clr = 1'b0;
        tick();
        model = 8'h00; cnt_m = 0; done_m = 1'b0;
        for (int k = 0; k < 300; k++) begin
            s     = ($urandom_range(0, 15) == 0);
            c     = ($urandom_range(0, 15) == 0);
            set   = s;
            clr   = c;
            en    = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom);
            d     = 8'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            exp   = ref_next(model, s, c, en, mode, d, sin_r, sin_l);
            done_m = 1'b0;
            if (s || c || (en && mode == 2'b11)) cnt_m = 0;
            else if (en && (mode == 2'b01 || mode == 2'b10) && cnt_m < 8) begin
                cnt_m++;
                done_m = (cnt_m == 8);
            end
            tick();
            n_tests++;
            if (q !== exp || sout_r !== exp[0] || sout_l !== exp[7]) begin
                n_fail++;
                $display("FAIL random_%0d: q=%h sr=%b sl=%b want %h", k, q, sout_r, sout_l, exp);
            end
`ifdef UNIV_SHIFT_REG_CNT_EN
            n_tests++;
            if (shift_cnt !== 4'(cnt_m) || shift_done !== done_m) begin
                n_fail++;
                $display("FAIL random_cnt_%0d: cnt=%0d done=%b want %0d %b", k, shift_cnt, shift_done, cnt_m, done_m);
            end
`endif
            model = exp;
        end
        set = 1'b0; clr = 1'b0;
    endtask

`ifdef UNIV_SHIFT_REG_CNT_EN
    task automatic test_counter();
        set = 1'b0; clr = 1'b0; en = 1'b1; mode = 2'b11; d = 8'h5A;
        tick();
        n_tests++;
        if (shift_cnt !== 4'd0 || shift_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_after_load: cnt=%0d done=%b want 0 0", shift_cnt, shift_done);
        end
        for (int k = 1; k <= 9; k++) begin
            mode = (k % 2 == 0) ? 2'b01 : 2'b10;
            sin_r = 1'($urandom); sin_l = 1'($urandom);
            tick();
            n_tests++;
            if (shift_cnt !== 4'((k > 8) ? 8 : k) || shift_done !== (k == 8)) begin
                n_fail++;
                $display("FAIL cnt_shift_%0d: cnt=%0d done=%b want %0d %b", k, shift_cnt, shift_done, (k > 8) ? 8 : k, (k == 8));
            end
        end
        mode = 2'b11;
        tick();
        n_tests++;
        if (shift_cnt !== 4'd0 || shift_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_reload: cnt=%0d done=%b want 0 0", shift_cnt, shift_done);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; set = 1'b0; clr = 1'b0;
        mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        model = 8'h00;
        test_reset();
        test_load_shift_right();
        test_shift_left_en();
        test_set_clr();
        test_glitch();
        test_random();
`ifdef UNIV_SHIFT_REG_CNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
